// File: rtl/ysyx_23060191_wbu_pkg.sv
// Shared write-back definitions: datapath width, result-source and load-type
// encodings, FSM states and the captured request payload.
package ysyx_23060191_wbu_pkg;

  localparam int unsigned CPU_WIDTH = 32;
  localparam int unsigned REG_AW    = 5;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } wbu_state_e;

  typedef struct packed {
    logic [CPU_WIDTH-1:0] pc;
    logic                 rd_wen;
    logic [REG_AW-1:0]    rd_addr;
    logic [2:0]           ld_funct3;
    logic [1:0]           addr_lo;
  } wb_req_t;

  // Result selection for every source except memory loads.
  function automatic logic [CPU_WIDTH-1:0] wb_result(
    input logic [1:0]           sel,
    input logic [CPU_WIDTH-1:0] alu,
    input logic [CPU_WIDTH-1:0] pc,
    input logic [CPU_WIDTH-1:0] csr
  );
    case (sel)
      WB_ALU:  return alu;
      WB_PC4:  return pc + CPU_WIDTH'(4);
      WB_CSR:  return csr;
      default: return alu;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060191_wbu_loadext.sv
// Combinational load lane select, sign/zero extension and alignment check.
module ysyx_23060191_LoadExt
  import ysyx_23060191_wbu_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [CPU_WIDTH-1:0] rdata,
  output logic [CPU_WIDTH-1:0] data,
  output logic                 misalign
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = rdata[{addr_lo, 3'b000} +: 8];
    half_v   = rdata[{addr_lo[1], 4'b0000} +: 16];
    data     = rdata;
    misalign = 1'b0;
    case (funct3)
      LD_LB:  data = {{(CPU_WIDTH-8){byte_v[7]}}, byte_v};
      LD_LBU: data = CPU_WIDTH'(byte_v);
      LD_LH: begin
        data     = {{(CPU_WIDTH-16){half_v[15]}}, half_v};
        misalign = addr_lo[0];
      end
      LD_LHU: begin
        data     = CPU_WIDTH'(half_v);
        misalign = addr_lo[0];
      end
      LD_LW: begin
        data     = rdata;
        misalign = (addr_lo != 2'b00);
      end
      // Unrecognised load types are treated as a full word.
      default: begin
        data     = rdata;
        misalign = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/ysyx_23060191_wbu.sv
// Write-back unit: accepts one instruction, optionally waits for load data,
// then drives a single-cycle GPR write and retirement pulse.
module ysyx_23060191_wbu
  import ysyx_23060191_wbu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CPU_WIDTH-1:0] in_pc,
  input  logic                 in_rd_wen,
  input  logic [REG_AW-1:0]    in_rd_addr,
  input  logic [1:0]           in_wb_sel,
  input  logic [CPU_WIDTH-1:0] in_alu_res,
  input  logic [CPU_WIDTH-1:0] in_csr_rdata,
  input  logic [2:0]           in_ld_funct3,
  input  logic [1:0]           in_addr_lo,
  input  logic                 mem_rvalid,
  input  logic [CPU_WIDTH-1:0] mem_rdata,
  output logic                 wr_en_Rd,
  output logic [REG_AW-1:0]    addr_Rd,
  output logic [CPU_WIDTH-1:0] data_Rd,
  output logic                 commit_valid,
  output logic [CPU_WIDTH-1:0] commit_pc,
  output logic                 ld_misalign
);

  wbu_state_e           state_q, state_d;
  wb_req_t              req_q, req_d;
  logic                 wen_d, commit_d, mis_d;
  logic [REG_AW-1:0]    addr_d;
  logic [CPU_WIDTH-1:0] data_d, pc_d;
  logic [CPU_WIDTH-1:0] ext_data;
  logic                 ext_misalign;

  ysyx_23060191_LoadExt u_loadext (
    .funct3   (req_q.ld_funct3),
    .addr_lo  (req_q.addr_lo),
    .rdata    (mem_rdata),
    .data     (ext_data),
    .misalign (ext_misalign)
  );

  // Next state and next output values; outputs are registered on the edge
  // that enters COMMIT so nothing from in_* reaches a port combinationally.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    wen_d    = 1'b0;
    commit_d = 1'b0;
    mis_d    = 1'b0;
    addr_d   = addr_Rd;
    data_d   = data_Rd;
    pc_d     = commit_pc;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          req_d.pc        = in_pc;
          req_d.rd_wen    = in_rd_wen;
          req_d.rd_addr   = in_rd_addr;
          req_d.ld_funct3 = in_ld_funct3;
          req_d.addr_lo   = in_addr_lo;
          if (in_wb_sel == WB_MEM) begin
            state_d = S_WAIT_MEM;
          end else begin
            state_d  = S_COMMIT;
            commit_d = 1'b1;
            pc_d     = in_pc;
            wen_d    = in_rd_wen;
            addr_d   = in_rd_addr;
            data_d   = wb_result(in_wb_sel, in_alu_res, in_pc, in_csr_rdata);
          end
        end
      end
      S_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d  = S_COMMIT;
          commit_d = 1'b1;
          pc_d     = req_q.pc;
          wen_d    = req_q.rd_wen && !ext_misalign;
          mis_d    = ext_misalign;
          addr_d   = req_q.rd_addr;
          data_d   = ext_data;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      in_ready     <= 1'b1;
      wr_en_Rd     <= 1'b0;
      addr_Rd      <= '0;
      data_Rd      <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      ld_misalign  <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      in_ready     <= (state_d == S_IDLE);
      wr_en_Rd     <= wen_d;
      addr_Rd      <= addr_d;
      data_Rd      <= data_d;
      commit_valid <= commit_d;
      commit_pc    <= pc_d;
      ld_misalign  <= mis_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_wbu.sv
// Directed, table-driven bench for the write-back unit.
module tb_ysyx_23060191_wbu;
  import ysyx_23060191_wbu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic        in_rd_wen;
  logic [4:0]  in_rd_addr;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_res;
  logic [31:0] in_csr_rdata;
  logic [2:0]  in_ld_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wr_en_Rd;
  logic [4:0]  addr_Rd;
  logic [31:0] data_Rd;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        ld_misalign;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] csr;
    logic [31:0] rdata;
    int          waitc;
    logic        e_wen;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  ysyx_23060191_wbu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rd_wen    (in_rd_wen),
    .in_rd_addr   (in_rd_addr),
    .in_wb_sel    (in_wb_sel),
    .in_alu_res   (in_alu_res),
    .in_csr_rdata (in_csr_rdata),
    .in_ld_funct3 (in_ld_funct3),
    .in_addr_lo   (in_addr_lo),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .wr_en_Rd     (wr_en_Rd),
    .addr_Rd      (addr_Rd),
    .data_Rd      (data_Rd),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .ld_misalign  (ld_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    in_wb_sel    = v.sel;
    in_ld_funct3 = v.f3;
    in_addr_lo   = v.lo;
    in_pc        = v.pc;
    in_rd_wen    = v.wen;
    in_rd_addr   = v.rd;
    in_alu_res   = v.alu;
    in_csr_rdata = v.csr;
  endtask

  // One full transaction starting from IDLE; checks the COMMIT cycle and the return to IDLE.
  task automatic do_txn(input vec_t v);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive('{default: '0});
    if (v.sel == WB_MEM) begin
      for (int w = 0; w < v.waitc; w++) begin
        chk("wait_commit", 32'(commit_valid), 32'd0);
        chk("wait_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    chk("commit_valid", 32'(commit_valid), 32'd1);
    chk("commit_pc", commit_pc, v.pc);
    chk("commit_ready", 32'(in_ready), 32'd0);
    chk("wr_en", 32'(wr_en_Rd), 32'(v.e_wen));
    chk("misalign", 32'(ld_misalign), 32'(v.e_mis));
    if (v.e_wen) begin
      chk("addr_Rd", 32'(addr_Rd), 32'(v.rd));
      chk("data_Rd", data_Rd, v.e_data);
    end
    @(posedge clk); #1;
    chk("post_commit", 32'(commit_valid), 32'd0);
    chk("post_wen", 32'(wr_en_Rd), 32'd0);
    chk("post_mis", 32'(ld_misalign), 32'd0);
    chk("post_ready", 32'(in_ready), 32'd1);
  endtask

  logic [31:0] b2b_pc[3];
  logic [31:0] b2b_alu[3];

  initial begin
    //          sel     f3      lo    pc            wen  rd    alu           csr           rdata         wt  ewen edata         emis
    vecs[0]  = '{WB_ALU, 3'd0,  2'd0, 32'h8000_0000, 1'b1, 5'd5,  32'h1234_5678, 32'h0,       32'h0,        0, 1'b1, 32'h1234_5678, 1'b0};
    vecs[1]  = '{WB_MEM, LD_LB, 2'd3, 32'h8000_0004, 1'b1, 5'd6,  32'h0,        32'h0,        32'h80FF_FFFF, 3, 1'b1, 32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{WB_MEM, LD_LHU,2'd2, 32'h8000_0008, 1'b1, 5'd7,  32'h0,        32'h0,        32'hBEEF_0000, 1, 1'b1, 32'h0000_BEEF, 1'b0};
    vecs[3]  = '{WB_MEM, LD_LW, 2'd1, 32'h8000_000C, 1'b1, 5'd8,  32'h0,        32'h0,        32'h1122_3344, 2, 1'b0, 32'h0,         1'b1};
    vecs[4]  = '{WB_PC4, 3'd0,  2'd0, 32'hFFFF_FFFC, 1'b1, 5'd1,  32'h0,        32'h0,        32'h0,        0, 1'b1, 32'h0000_0000, 1'b0};
    vecs[5]  = '{WB_CSR, 3'd0,  2'd0, 32'h8000_0010, 1'b1, 5'd10, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0,      0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{WB_MEM, LD_LH, 2'd2, 32'h8000_0014, 1'b1, 5'd11, 32'h0,        32'h0,        32'h8001_0000, 0, 1'b1, 32'hFFFF_8001, 1'b0};
    vecs[7]  = '{WB_MEM, LD_LBU,2'd1, 32'h8000_0018, 1'b1, 5'd12, 32'h0,        32'h0,        32'h0000_AB00, 1, 1'b1, 32'h0000_00AB, 1'b0};
    vecs[8]  = '{WB_MEM, 3'b111,2'd0, 32'h8000_001C, 1'b1, 5'd13, 32'h0,        32'h0,        32'hCAFE_F00D, 0, 1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{WB_MEM, LD_LH, 2'd1, 32'h8000_0020, 1'b1, 5'd14, 32'h0,        32'h0,        32'h1234_5678, 0, 1'b0, 32'h0,         1'b1};
    vecs[10] = '{WB_ALU, 3'd0,  2'd0, 32'h8000_0024, 1'b1, 5'd0,  32'h0000_0055, 32'h0,       32'h0,        0, 1'b1, 32'h0000_0055, 1'b0};
    vecs[11] = '{WB_ALU, 3'd0,  2'd0, 32'h8000_0028, 1'b0, 5'd3,  32'h0000_0077, 32'h0,       32'h0,        0, 1'b0, 32'h0,         1'b0};
    vecs[12] = '{WB_MEM, LD_LB, 2'd0, 32'h8000_002C, 1'b1, 5'd15, 32'h0,        32'h0,        32'h0000_007F, 0, 1'b1, 32'h0000_007F, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    drive('{default: '0});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wen", 32'(wr_en_Rd), 32'd0);
    chk("rst_addr", 32'(addr_Rd), 32'd0);
    chk("rst_data", data_Rd, 32'd0);
    chk("rst_commit", 32'(commit_valid), 32'd0);
    chk("rst_pc", commit_pc, 32'd0);
    chk("rst_mis", 32'(ld_misalign), 32'd0);
    rst_n = 1'b1;

    // First vector is presented on the first edge after reset release.
    for (int i = 0; i < NV; i++) do_txn(vecs[i]);

    // Memory response while idle must not produce a commit.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("idle_rvalid_commit", 32'(commit_valid), 32'd0);
    chk("idle_rvalid_wen", 32'(wr_en_Rd), 32'd0);
    chk("idle_rvalid_ready", 32'(in_ready), 32'd1);

    // Reset while waiting for load data drops the pending load.
    drive(vecs[1]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("wait_ready_pre_rst", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    chk("async_rst_commit", 32'(commit_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8000_0000;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst_drop_commit", 32'(commit_valid), 32'd0);
      chk("rst_drop_wen", 32'(wr_en_Rd), 32'd0);
      chk("rst_drop_ready", 32'(in_ready), 32'd1);
    end
    mem_rvalid = 1'b0;

    // Back-to-back ALU instructions with in_valid held high.
    b2b_pc[0] = 32'h0000_1000; b2b_alu[0] = 32'hA0A0_0001;
    b2b_pc[1] = 32'h0000_1004; b2b_alu[1] = 32'hA0A0_0002;
    b2b_pc[2] = 32'h0000_1008; b2b_alu[2] = 32'hA0A0_0003;
    begin
      int idx = 0;
      int commits = 0;
      logic rdy_before;
      in_wb_sel = WB_ALU; in_rd_wen = 1'b1; in_rd_addr = 5'd9;
      in_pc = b2b_pc[0]; in_alu_res = b2b_alu[0];
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 20 && commits < 3; cyc++) begin
        rdy_before = in_ready;
        @(posedge clk); #1;
        if (rdy_before && in_valid) begin
          idx++;
          if (idx == 3) in_valid = 1'b0;
          else begin
            in_pc = b2b_pc[idx];
            in_alu_res = b2b_alu[idx];
          end
        end
        if (commit_valid) begin
          chk("b2b_pc", commit_pc, b2b_pc[commits]);
          chk("b2b_data", data_Rd, b2b_alu[commits]);
          chk("b2b_ready_low", 32'(in_ready), 32'd0);
          commits++;
        end
      end
      in_valid = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        if (commit_valid) commits++;
      end
      chk("b2b_commit_count", 32'(commits), 32'd3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
